// File: rtl/tiny16_pkg.sv
// ============================================================================
// tiny16_pkg : shared types and constants for the tiny16 memory arbiter
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package tiny16_pkg;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_OPEN      = 2'd0,
        ST_LOCKED_M0 = 2'd1,
        ST_LOCKED_M1 = 2'd2
    } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester and memory-side bus bundle for mem_arbiter
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if
    import tiny16_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();
    logic          req0,  req1;
    logic          lock0, lock1;
    logic          we0,   we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,  gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata
    );

    // Requester / memory model side
    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational two-way round-robin selector (ties go to !last)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_pick
    import tiny16_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last == M1)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin arbiter for the unified tiny16 memory with
//               bounded burst lock. MEM_ARBITER_STATS_EN adds grant/wait counters.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import tiny16_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic [15:0]   wait1
`endif
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    arb_state_t    state;
    logic          last;
    logic [7:0]    lock_cnt;
    logic [7:0]    cnt_nxt;
    logic [1:0]    req_v;
    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic          own_m;
    logic          own_req;
    logic          own_lock;
    logic          own_gnt;
    logic          other_req;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          cur_we;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;

    assign req_v = {bus.req1, bus.req0};

    rr_pick u_pick (
        .req  (req_v),
        .last (last),
        .gnt  (pick)
    );

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (state)
                ST_OPEN:      gnt = pick;
                ST_LOCKED_M0: gnt = {1'b0, bus.req0};
                ST_LOCKED_M1: gnt = {bus.req1, 1'b0};
                default:      gnt = 2'b00;
            endcase
        end
    end

    // "own" is the locking master in LOCKED_x, or the granted master in OPEN
    assign own_m     = (state == ST_LOCKED_M1) || ((state == ST_OPEN) && gnt[1]);
    assign own_req   = own_m ? bus.req1  : bus.req0;
    assign own_lock  = own_m ? bus.lock1 : bus.lock0;
    assign other_req = own_m ? bus.req0  : bus.req1;
    assign own_gnt   = |gnt;
    assign cnt_nxt   = (own_gnt && (lock_cnt != MAX_CNT)) ? lock_cnt + 8'd1 : lock_cnt;

    assign cur_addr  = gnt[1] ? bus.addr1  : bus.addr0;
    assign cur_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
    assign cur_we    = gnt[1] ? bus.we1    : bus.we0;

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.mem_addr  = own_gnt ? cur_addr  : addr_hold;
    assign bus.mem_wdata = own_gnt ? cur_wdata : wdata_hold;
    assign bus.mem_we    = own_gnt & cur_we;
    assign bus.rdata     = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OPEN;
            last        <= M1;
            lock_cnt    <= 8'd0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            addr_hold   <= '0;
            wdata_hold  <= '0;
        end else begin
            bus.rvalid0 <= gnt[0] & ~bus.we0;
            bus.rvalid1 <= gnt[1] & ~bus.we1;
            if (own_gnt) begin
                last       <= gnt[1];
                addr_hold  <= cur_addr;
                wdata_hold <= cur_wdata;
            end
            case (state)
                ST_OPEN: begin
                    // With MAX_LOCK==1 a contested first grant already exhausts the lock
                    if (own_gnt && own_lock && !(other_req && (MAX_CNT == 8'd1))) begin
                        state    <= gnt[1] ? ST_LOCKED_M1 : ST_LOCKED_M0;
                        lock_cnt <= 8'd1;
                    end
                end
                ST_LOCKED_M0, ST_LOCKED_M1: begin
                    if ((own_gnt && !own_lock) ||
                        (!own_req && !own_lock) ||
                        (other_req && (cnt_nxt == MAX_CNT))) begin
                        state    <= ST_OPEN;
                        lock_cnt <= 8'd0;
                    end else begin
                        lock_cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state    <= ST_OPEN;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0 <= 16'd0;
            gcnt1 <= 16'd0;
            wait1 <= 16'd0;
        end else begin
            if (gnt[0] && (gcnt0 != 16'hFFFF)) begin
                gcnt0 <= gcnt0 + 16'd1;
            end
            if (gnt[1] && (gcnt1 != 16'hFFFF)) begin
                gcnt1 <= gcnt1 + 16'd1;
            end
            if (bus.req1 && !gnt[1] && (wait1 != 16'hFFFF)) begin
                wait1 <= wait1 + 16'd1;
            end
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed, table-driven bench for mem_arbiter (MAX_LOCK 8 and 4)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus8 ();
    mem_arbiter_if #(.AW(16), .DW(16)) bus4 ();

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] gc0_8, gc1_8, wt1_8, gc0_4, gc1_4, wt1_4;
`endif

    mem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .gcnt0 (gc0_8),
        .gcnt1 (gc1_8),
        .wait1 (wt1_8)
`endif
    );

    mem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .gcnt0 (gc0_4),
        .gcnt1 (gc1_4),
        .wait1 (wt1_4)
`endif
    );

    // Synchronous memories with one-cycle read latency, read-before-write
    logic [15:0] mem8 [256];
    logic [15:0] mem4 [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem8[i] = 16'hA000 + 16'(i);
            mem4[i] = 16'hA000 + 16'(i);
        end
        mem8[2] = 16'h3430;
        mem4[2] = 16'h3430;
        bus8.mem_rdata = 16'h0000;
        bus4.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            bus8.mem_rdata <= mem8[bus8.mem_addr[7:0]];
            bus4.mem_rdata <= mem4[bus4.mem_addr[7:0]];
            if (bus8.mem_we) mem8[bus8.mem_addr[7:0]] = bus8.mem_wdata;
            if (bus4.mem_we) mem4[bus4.mem_addr[7:0]] = bus4.mem_wdata;
        end
    end

    typedef struct {
        logic [5:0]  ctl;   // {req0, req1, lock0, lock1, we0, we1}
        logic [15:0] a0, a1, d0, d1;
        logic [4:0]  ex;    // {gnt0, gnt1, rvalid0, rvalid1, mem_we}
        logic [15:0] eaddr;
        logic [15:0] erd;   // checked only when an rvalid is expected
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] ctl, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] d0, input logic [15:0] d1);
        {bus8.req0, bus8.req1, bus8.lock0, bus8.lock1, bus8.we0, bus8.we1} = ctl;
        {bus4.req0, bus4.req1, bus4.lock0, bus4.lock1, bus4.we0, bus4.we1} = ctl;
        bus8.addr0 = a0;  bus8.addr1 = a1;  bus8.wdata0 = d0;  bus8.wdata1 = d1;
        bus4.addr0 = a0;  bus4.addr1 = a1;  bus4.wdata0 = d0;  bus4.wdata1 = d1;
    endtask

    function automatic vec_t mk(input logic [5:0] ctl, input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] d0, input logic [15:0] d1, input logic [4:0] ex,
                                input logic [15:0] eaddr, input logic [15:0] erd);
        vec_t v;
        v.ctl = ctl;  v.a0 = a0;  v.a1 = a1;  v.d0 = d0;  v.d1 = d1;
        v.ex  = ex;   v.eaddr = eaddr;  v.erd = erd;
        return v;
    endfunction

    vec_t        vecs [20];
    logic [1:0]  st_req [8];
    logic [1:0]  st_gnt [8];
    logic        found;

    initial begin
        // Arbitration, read latency, write, hold, burst lock, idle lock
        vecs[0]  = mk(6'b110000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b10000, 16'h0002, 16'h0000);
        vecs[1]  = mk(6'b110000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b01100, 16'h0010, 16'h3430);
        vecs[2]  = mk(6'b110000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b10010, 16'h0002, 16'hA010);
        vecs[3]  = mk(6'b100000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b10100, 16'h0002, 16'h3430);
        vecs[4]  = mk(6'b110010, 16'h0005, 16'h0010, 16'h5555, 16'h0000, 5'b01100, 16'h0010, 16'h3430);
        vecs[5]  = mk(6'b100010, 16'h0005, 16'h0010, 16'h5555, 16'h0000, 5'b10011, 16'h0005, 16'hA010);
        vecs[6]  = mk(6'b000000, 16'h0077, 16'h0066, 16'h0000, 16'h0000, 5'b00000, 16'h0005, 16'h0000);
        vecs[7]  = mk(6'b100000, 16'h0005, 16'h0010, 16'h0000, 16'h0000, 5'b10000, 16'h0005, 16'h0000);
        vecs[8]  = mk(6'b000000, 16'h0077, 16'h0066, 16'h0000, 16'h0000, 5'b00100, 16'h0005, 16'h5555);
        vecs[9]  = mk(6'b110101, 16'h0002, 16'h0000, 16'h0000, 16'h1000, 5'b01001, 16'h0000, 16'h0000);
        vecs[10] = mk(6'b110101, 16'h0002, 16'h0001, 16'h0000, 16'h1001, 5'b01001, 16'h0001, 16'h0000);
        vecs[11] = mk(6'b110101, 16'h0002, 16'h0002, 16'h0000, 16'h1002, 5'b01001, 16'h0002, 16'h0000);
        vecs[12] = mk(6'b110001, 16'h0002, 16'h0003, 16'h0000, 16'h1003, 5'b01001, 16'h0003, 16'h0000);
        vecs[13] = mk(6'b110000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b10000, 16'h0002, 16'h0000);
        vecs[14] = mk(6'b000000, 16'h0077, 16'h0066, 16'h0000, 16'h0000, 5'b00100, 16'h0002, 16'h1002);
        vecs[15] = mk(6'b010100, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b01000, 16'h0010, 16'h0000);
        vecs[16] = mk(6'b100100, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b00010, 16'h0010, 16'hA010);
        vecs[17] = mk(6'b100000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b00000, 16'h0010, 16'h0000);
        vecs[18] = mk(6'b100000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 5'b10000, 16'h0002, 16'h0000);
        vecs[19] = mk(6'b000000, 16'h0077, 16'h0066, 16'h0000, 16'h0000, 5'b00100, 16'h0002, 16'h1002);

        st_req = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b10};
        st_gnt = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};

        // Reset held with both masters requesting, M0 asking to write
        rst_n = 1'b0;
        set_in(6'b110010, 16'h0002, 16'h0010, 16'h1111, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt", {bus8.gnt0, bus8.gnt1, bus8.mem_we}, 3'b000);
        chk("reset_rvalid", {bus8.rvalid0, bus8.rvalid1}, 2'b00);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            set_in(vecs[i].ctl, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #1;
            chk($sformatf("row%0d_ctl", i),
                {bus8.gnt0, bus8.gnt1, bus8.rvalid0, bus8.rvalid1, bus8.mem_we}, vecs[i].ex);
            chk($sformatf("row%0d_addr", i), bus8.mem_addr, vecs[i].eaddr);
            if (vecs[i].ex[2] || vecs[i].ex[1])
                chk($sformatf("row%0d_rdata", i), bus8.rdata, vecs[i].erd);
        end

        // Forced release: M1 holds LOCK1 permanently while M0 keeps requesting
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(6'b110101, 16'h0002, 16'h0020 + 16'(i), 16'h0000, 16'hB000 + 16'(i));
            #1;
            chk($sformatf("force8_%0d", i), {bus8.gnt1, bus8.gnt0},
                ((i < 8) || (i == 9)) ? 2'b10 : 2'b01);
            chk($sformatf("force4_%0d", i), {bus4.gnt1, bus4.gnt0},
                ((i < 4) || ((i >= 5) && (i <= 8))) ? 2'b10 : 2'b01);
        end

        // Mid-burst reset: dut8 is in LOCKED_M1, dut4 has a read response pending
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", {bus8.gnt0, bus8.gnt1, bus4.gnt0, bus4.gnt1}, 4'b0000);
        chk("midrst_rvalid", {bus8.rvalid0, bus8.rvalid1, bus4.rvalid0, bus4.rvalid1}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_tie8", {bus8.gnt0, bus8.gnt1}, 2'b10);
        chk("midrst_tie4", {bus4.gnt0, bus4.gnt1}, 2'b10);

        // Saturated lock with the other master idle keeps the owner going
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(6'b010100, 16'h0002, 16'h0030, 16'h0000, 16'h0000);
            #1;
            chk($sformatf("sat4_%0d", i), {bus4.gnt0, bus4.gnt1}, 2'b01);
        end
        found = 1'b0;
        for (int k = 0; k < 3 && !found; k++) begin
            @(negedge clk);
            set_in(6'b110100, 16'h0002, 16'h0030, 16'h0000, 16'h0000);
            #1;
            if (bus4.gnt0) found = 1'b1;
        end
        chk("sat4_release", found, 1'b1);

        // Plain round-robin after reset: 5 grants to M0, 3 to M1, M1 waits twice
        @(negedge clk);
        rst_n = 1'b0;
        set_in(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            set_in({st_req[i], 4'b0000}, 16'h0002, 16'h0010, 16'h0000, 16'h0000);
            #1;
            chk($sformatf("stat_seq%0d", i), {bus8.gnt0, bus8.gnt1}, st_gnt[i]);
        end
        @(negedge clk);
        set_in(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
`ifdef MEM_ARBITER_STATS_EN
        chk("gcnt0", gc0_8, 16'd5);
        chk("gcnt1", gc1_8, 16'd3);
        chk("wait1", wt1_8, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified tiny16 memory between two requesters: M0 is the CPU control/step unit (fetch and load/store); M1 is the program loader/debug port.
- Sits between the requesters and the memory block; sole driver of the memory address, write-enable and write-data.
- Round-robin arbitration with a bounded per-master lock for bursts (e.g. loader writing a program image).
- Read data returns one cycle after grant, tagged per master.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_LOCK, 8, max consecutive locked grants before forced release (1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0, REQ1  in  1 each  access request; held with ADDR/WE/WDATA until GNT seen.
- LOCK0, LOCK1  in  1 each  request exclusive hold for following access.
- WE0, WE1  in  1 each  1 = write, 0 = read.
- ADDR0, ADDR1  in  AW each  access address.
- WDATA0, WDATA1  in  DW each  write data.
- GNT0, GNT1  out  1 each  combinational grant; the access executes this cycle.
- RVALID0, RVALID1  out  1 each  registered; RDATA valid for the read granted the previous cycle.
- RDATA  out  DW  memory read data (pass-through of MEM_RDATA).
- MEM_ADDR  out  AW  memory address.
- MEM_WE  out  1  memory write enable.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data, valid 1 cycle after address.

Behaviour:
- Reset (async, RST_N=0): state=OPEN, last=M1 (M0 wins first tie), lock_cnt=0, RVALIDx=0. GNTx=0 and MEM_WE=0 while RST_N=0. Mid-operation reset abandons any lock and pending RVALID.
- At most one GNT per cycle. MEM_* mirror the granted master's ADDR/WE/WDATA. With no grant: MEM_WE=0, MEM_ADDR/MEM_WDATA hold the last granted values.
- State OPEN:
  - One REQ: that master is granted.
  - Both REQ: the master other than `last` is granted.
  - On a grant with LOCKx=1: go to LOCKED_x, lock_cnt=1.
  - `last` updates on every grant.
- State LOCKED_x:
  - Only x may be granted; the other master waits (GNT=0) even if x is idle.
  - Exit to OPEN on any of:
    - a grant to x with LOCKx=0;
    - REQx=0 and LOCKx=0;
    - lock_cnt==MAX_LOCK with the other master requesting. Forced release: that grant to x completes, then the other master wins the next tie.
  - lock_cnt increments per grant and saturates at MAX_LOCK.
  - If lock_cnt==MAX_LOCK and the other master is idle, x continues and the counter stays saturated.
- Read latency: RVALIDx is set on the edge after a cycle with GNTx=1 and WEx=0, and lasts 1 cycle. Back-to-back reads are allowed, one per cycle.
- Writes produce no RVALID.
- REQx dropped without a grant: no side effects.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: adds outputs GCNT0 and GCNT1 (16 bits each) and WAIT1 (16 bits).
  - GCNTx: saturating count of grants to master x.
  - WAIT1: saturating count of cycles with REQ1=1 and GNT1=0.
  - All three clear on reset.
- Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package tiny16_pkg:
  - AW/DW defaults.
  - Arbiter state enum (OPEN, LOCKED_M0, LOCKED_M1).
  - Master index constants M0/M1.
- Sub-module rr_pick: pure combinational 2-way round-robin selector (req[1:0], last → gnt[1:0]). Reused for any future third requester.
- The lock FSM, counters and RVALID registers stay in mem_arbiter.

Test Plan:
- Reset: RST_N=0 with REQ0=REQ1=1 → GNT0=GNT1=0, MEM_WE=0, RVALID=0. Release RST_N, both still requesting → GNT0 first cycle, GNT1 second, alternating thereafter.
- Read latency: M0 reads ADDR0=0x0002 with mem[2]=0x3430 → GNT0 in cycle k; RVALID0=1, RDATA=0x3430 in cycle k+1; RVALID1 stays 0.
- Loader burst: M1 holds LOCK1=1 and writes 0x0000..0x0003 while REQ0=1, MAX_LOCK=8 → four consecutive GNT1. Last write has LOCK1=0 → GNT0 the next cycle.
- Forced release: MAX_LOCK=4, M1 locked with LOCK1 always 1, REQ0=1 → exactly 4 GNT1, then GNT0, then arbitration resumes.
- Mid-burst reset: assert RST_N=0 during LOCKED_M1 → after release, state=OPEN and M0 wins the tie.
- With MEM_ARBITER_STATS_EN: 5 grants to M0 and 3 to M1, with M1 waiting 2 cycles → GCNT0=5, GCNT1=3, WAIT1=2.
